// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the ECP5 EHXPLLL control and phase-stepping logic.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_IDLE      = 3'd1,
        ST_SETUP     = 3'd2,
        ST_STEP_L    = 3'd3,
        ST_STEP_H    = 3'd4,
        ST_SETTLE    = 3'd5
    } state_t;

    localparam logic [1:0] SEL_CLKOP  = 2'd0;
    localparam logic [1:0] SEL_CLKOS  = 2'd1;
    localparam logic [1:0] SEL_CLKOS2 = 2'd2;
    localparam logic [1:0] SEL_CLKOS3 = 2'd3;

    localparam int unsigned DEF_LOCK_FILTER = 1024;
    localparam int unsigned DEF_STEP_LO     = 4;
    localparam int unsigned DEF_STEP_HI     = 4;
    localparam int unsigned DEF_SETTLE      = 16;

    localparam int unsigned STEP_CNT_W = 8;

    typedef struct packed {
        logic [1:0]            sel;
        logic                  dir;
        logic [STEP_CNT_W-1:0] steps;
    } phase_req_t;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Timers count down from N-1, so the widest delay sets the width (never below 1 bit).
    function automatic int unsigned timer_width(input int unsigned lo,
                                                 input int unsigned hi,
                                                 input int unsigned settle);
        int unsigned w;
        w = $clog2(max3(lo, hi, settle));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pll_lock_filter.sv
// PLL LOCK qualification: synchroniser, consecutive-cycle filter, lock_ok/lock_lost and
// the registered downstream reset.
module pll_lock_filter
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_FILTER = DEF_LOCK_FILTER
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pll_locked,
    output logic o_lock_ok,
    output logic o_lock_lost,
    output logic o_sys_rst
);

    localparam int unsigned      CNT_W   = $clog2(LOCK_FILTER);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILTER - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lock_ok;
    logic             r_lock_ok_q;
    logic             r_lock_lost;
    logic             r_sys_rst;

    // Two-flop synchroniser for the asynchronous LOCK pin.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    // Saturating run-length counter; any low sample drops lock at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_lock_ok <= 1'b0;
        end else if (!r_sync2) begin
            r_cnt     <= '0;
            r_lock_ok <= 1'b0;
        end else if (r_cnt == CNT_MAX) begin
            r_lock_ok <= 1'b1;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_lock_ok_q <= 1'b0;
            r_lock_lost <= 1'b0;
            r_sys_rst   <= 1'b1;
        end else begin
            r_lock_ok_q <= r_lock_ok;
            r_lock_lost <= r_lock_ok_q & ~r_lock_ok;
            r_sys_rst   <= ~r_lock_ok;
        end
    end

    assign o_lock_ok   = r_lock_ok;
    assign o_lock_lost = r_lock_lost;
    assign o_sys_rst   = r_sys_rst;

endmodule

// File: rtl/pll_phase_ctrl.sv
// EHXPLLL sequencer: lock qualification plus PHASESEL/PHASEDIR/PHASESTEP pulse generation
// for dynamic phase-shift requests.
module pll_phase_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned LOCK_FILTER = DEF_LOCK_FILTER,
    parameter int unsigned STEP_LO     = DEF_STEP_LO,
    parameter int unsigned STEP_HI     = DEF_STEP_HI,
    parameter int unsigned SETTLE      = DEF_SETTLE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pll_locked,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_sel,
    input  logic                  i_req_dir,
    input  logic [STEP_CNT_W-1:0] i_req_steps,
    output logic [1:0]            o_phasesel,
    output logic                  o_phasedir,
    output logic                  o_phasestep,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_lock_ok,
    output logic                  o_lock_lost,
    output logic                  o_sys_rst
);

    localparam int unsigned      TMR_W      = timer_width(STEP_LO, STEP_HI, SETTLE);
    localparam logic [TMR_W-1:0] TMR_LO     = TMR_W'(STEP_LO - 1);
    localparam logic [TMR_W-1:0] TMR_HI     = TMR_W'(STEP_HI - 1);
    localparam logic [TMR_W-1:0] TMR_SETTLE = TMR_W'(SETTLE - 1);

    logic w_lock_ok;

    pll_lock_filter #(
        .LOCK_FILTER (LOCK_FILTER)
    ) u_lock_filter (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pll_locked (i_pll_locked),
        .o_lock_ok    (w_lock_ok),
        .o_lock_lost  (o_lock_lost),
        .o_sys_rst    (o_sys_rst)
    );

    phase_req_t w_req;
    assign w_req = '{sel: i_req_sel, dir: i_req_dir, steps: i_req_steps};

    state_t                r_state;
    state_t                w_state_next;
    logic [STEP_CNT_W-1:0] r_steps_left;
    logic [STEP_CNT_W-1:0] w_steps_left_next;
    logic [TMR_W-1:0]      r_timer;
    logic [TMR_W-1:0]      w_timer_next;
    logic [1:0]            r_phasesel;
    logic [1:0]            w_phasesel_next;
    logic                  r_phasedir;
    logic                  w_phasedir_next;
    logic                  r_phasestep;
    logic                  w_phasestep_next;
    logic                  r_req_ready;
    logic                  w_req_ready_next;
    logic                  r_busy;
    logic                  w_busy_next;
    logic                  r_done;
    logic                  w_done_next;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_WAIT_LOCK;
            r_steps_left <= '0;
            r_timer      <= '0;
            r_phasesel   <= SEL_CLKOP;
            r_phasedir   <= 1'b0;
            r_phasestep  <= 1'b1;
            r_req_ready  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_steps_left <= w_steps_left_next;
            r_timer      <= w_timer_next;
            r_phasesel   <= w_phasesel_next;
            r_phasedir   <= w_phasedir_next;
            r_phasestep  <= w_phasestep_next;
            r_req_ready  <= w_req_ready_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_steps_left_next = r_steps_left;
        w_timer_next      = r_timer;
        w_phasesel_next   = r_phasesel;
        w_phasedir_next   = r_phasedir;
        w_done_next       = 1'b0;

        // Losing lock anywhere outside WAIT_LOCK abandons the request without a done.
        if ((r_state != ST_WAIT_LOCK) && !w_lock_ok) begin
            w_state_next      = ST_WAIT_LOCK;
            w_steps_left_next = '0;
            w_timer_next      = '0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    if (w_lock_ok) begin
                        w_state_next = ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (i_req_valid && r_req_ready) begin
                        w_phasesel_next   = w_req.sel;
                        w_phasedir_next   = w_req.dir;
                        w_steps_left_next = w_req.steps;
                        w_state_next      = ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (r_steps_left == '0) begin
                        w_state_next = ST_SETTLE;
                        w_timer_next = TMR_SETTLE;
                    end else begin
                        w_state_next = ST_STEP_L;
                        w_timer_next = TMR_LO;
                    end
                end
                ST_STEP_L: begin
                    if (r_timer == '0) begin
                        w_state_next      = ST_STEP_H;
                        w_timer_next      = TMR_HI;
                        w_steps_left_next = r_steps_left - STEP_CNT_W'(1);
                    end else begin
                        w_timer_next = r_timer - TMR_W'(1);
                    end
                end
                ST_STEP_H: begin
                    if (r_timer != '0) begin
                        w_timer_next = r_timer - TMR_W'(1);
                    end else if (r_steps_left == '0) begin
                        w_state_next = ST_SETTLE;
                        w_timer_next = TMR_SETTLE;
                    end else begin
                        w_state_next = ST_STEP_L;
                        w_timer_next = TMR_LO;
                    end
                end
                ST_SETTLE: begin
                    if (r_timer == '0) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_timer_next = r_timer - TMR_W'(1);
                    end
                end
                default: begin
                    w_state_next = ST_WAIT_LOCK;
                end
            endcase
        end

        // Pin-level outputs are registered copies of what the next state implies.
        w_phasestep_next = (w_state_next != ST_STEP_L);
        w_req_ready_next = (w_state_next == ST_IDLE);
        w_busy_next      = (w_state_next == ST_SETUP)  || (w_state_next == ST_STEP_L) ||
                           (w_state_next == ST_STEP_H) || (w_state_next == ST_SETTLE);
    end

    assign o_req_ready = r_req_ready;
    assign o_phasesel  = r_phasesel;
    assign o_phasedir  = r_phasedir;
    assign o_phasestep = r_phasestep;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_lock_ok   = w_lock_ok;

endmodule
